// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 8 {a,b,c} vectors into a 3-input boolean
// block, samples its d output after a settle time, and counts mismatches
// against the EXPECTED truth table.
// Optional feature macro: MISMATCH_CAPTURE_EN (adds fail_valid / fail_vec,
// which record the vector of the first mismatch in a sweep).
module truth_table_sweeper #(
    parameter logic [7:0] EXPECTED      = 8'h15,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       d_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
`ifdef MISMATCH_CAPTURE_EN
    output logic       fail_valid,
    output logic [2:0] fail_vec,
`endif
    output logic [3:0] err_count
);

    localparam int WW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      vec;
    logic [WW-1:0]   wait_cnt;
    logic            mismatch;
    logic [3:0]      err_nxt;

    // The stimulus is the vector register itself, so a,b,c are registered.
    assign {a, b, c} = vec;
    assign mismatch  = (state == SAMPLE) && (d_in != EXPECTED[vec]);
    assign err_nxt   = err_count + 4'(mismatch);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status decode
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = SETTLE;
            SETTLE: begin
                busy = 1'b1;
                if (wait_cnt == WAIT_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                busy      = 1'b1;
                state_nxt = (vec == 3'd7) ? DONE : SETTLE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: vector, settle counter, error count and verdict.
    // pass is resolved on the edge leaving the last SAMPLE so it is already
    // valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= 3'd0;
            wait_cnt   <= '0;
            err_count  <= 4'd0;
            pass       <= 1'b0;
`ifdef MISMATCH_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    vec        <= 3'd0;
                    wait_cnt   <= '0;
                    err_count  <= 4'd0;
                    pass       <= 1'b0;
`ifdef MISMATCH_CAPTURE_EN
                    fail_valid <= 1'b0;
                    fail_vec   <= 3'd0;
`endif
                end
                SETTLE: wait_cnt <= wait_cnt + 1'b1;
                SAMPLE: begin
                    err_count <= err_nxt;
`ifdef MISMATCH_CAPTURE_EN
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                    end
`endif
                    if (vec == 3'd7) begin
                        pass <= (err_nxt == 4'd0);
                    end else begin
                        vec      <= vec + 3'd1;
                        wait_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
